fft_butterfly_sequencer: RTL
============================

Name: fft_butterfly_sequencer

Overview:
- Controller that sequences the shared radix-2 butterfly adder datapath through all stages of an in-place N-point FFT (N = 2^SIZE).
- Generates sample-RAM read/write address pairs, twiddle ROM address, butterfly `en`, and `en_modify` (last-stage modified add).
- Sits between the top-level FFT control (start/done) and the sample RAM, twiddle ROM and butterfly adder.
- One butterfly is issued per clock, with hazard bubbles inserted between stages.

Parameters:
- SIZE, 4, log2 of FFT length; number of stages; address width.
- BF_LAT, 2, cycles from read issue to write-back of the same butterfly; must be >= 1.
- STG_W, 3, width of the stage number output; must hold the value SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a transform; sampled only in IDLE.
- busy  out  1  high from first issue cycle through last write cycle.
- done  out  1  one-cycle pulse after the final write-back.
- rd_valid  out  1  read request to sample RAM this cycle.
- rd_addr_a  out  SIZE  upper butterfly input address.
- rd_addr_b  out  SIZE  lower butterfly input address.
- tw_addr  out  SIZE-1  twiddle ROM address for the issued butterfly.
- en  out  1  butterfly adder enable; equals rd_valid delayed 1 cycle.
- en_modify  out  1  high with `en` when that butterfly belongs to stage SIZE.
- stage  out  STG_W  stage of the currently issuing butterfly (1..SIZE); 0 in IDLE.
- wr_en  out  1  write-back strobe; equals rd_valid delayed BF_LAT cycles.
- wr_addr_a  out  SIZE  rd_addr_a delayed BF_LAT cycles.
- wr_addr_b  out  SIZE  rd_addr_b delayed BF_LAT cycles.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - All outputs and all delay-line registers go to 0 immediately.
  - Reset mid-transform abandons the transform: no done pulse, no further wr_en.
- FSM states:
  - IDLE: on start=1, go to ISSUE with stage=1, k=0.
  - ISSUE: rd_valid=1, k increments each cycle. When k = N/2-1: if stage<SIZE go to BUBBLE, else go to DRAIN.
  - BUBBLE: rd_valid=0 for exactly BF_LAT cycles, then stage+1, k=0, return to ISSUE. The bubbles guarantee the previous stage's writes land before the next stage reads.
  - DRAIN: wait BF_LAT cycles until the last wr_en is seen, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Address generation (DIT, in-place), for stage s and butterfly index k:
  - span = 2^(s-1)
  - pos = k mod span
  - grp = k / span
  - rd_addr_a = grp·2·span + pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << (SIZE-s)
- Address outputs are registered and valid only when rd_valid=1; they hold their last value otherwise.
- en_modify is the registered flag (stage==SIZE) aligned with `en`. It is 0 whenever en=0.
- Timing: start sampled at edge 0 gives first rd_valid in cycle 1.
- Total busy cycles = SIZE·N/2 + SIZE·BF_LAT.
- Defaults (SIZE=4, BF_LAT=2):
  - rd_valid high in cycles 1–8, 11–18, 21–28, 31–38.
  - Last wr_en in cycle 40.
  - done in cycle 41.
  - busy high for cycles 1–40.
- start while not IDLE: ignored, no queueing.
- start asserted in the same cycle as done: ignored; a new transform requires start in IDLE.
- Counters wrap by FSM control only; k never exceeds N/2-1, stage never exceeds SIZE.

Optional Feature:
- Macro: FFT_SEQ_HOLD_EN.
- When defined:
  - Adds input port `hold` (1 bit).
  - While hold=1, FSM, counters and all delay-line registers freeze.
  - en, wr_en and rd_valid are forced to 0 during hold.
  - Delayed entries resume unchanged when hold drops, so the cycle counts above stretch by exactly the number of held cycles.
  - done is never asserted while hold=1; a pending done is deferred.
- When undefined: no `hold` port; behaviour exactly as above.

Test Plan:
- Reset then idle: rst_n low 3 cycles, start=0 → all outputs 0, stage=0, no rd_valid for 50 cycles.
- Single transform, defaults: start at cycle 0 →
  - stage 1 pairs (0,1),(2,3)…(14,15) with tw_addr=0.
  - stage 4 pairs (0,8)…(7,15) with tw_addr 0..7.
  - rd_valid count = 32; done at cycle 41 exactly once.
- Hazard spacing: check that the last wr_en of stage s precedes the first rd_valid of stage s+1 (write cycle 10 vs read cycle 11 for s=1) → no read of an unwritten address.
- en_modify: en_modify=1 exactly during en cycles 32–39 and 0 on all other en cycles; wr_addr equals rd_addr delayed 2.
- Mid-run reset and ignored start:
  - start pulses at cycles 5 and 41 (same cycle as done) → both ignored.
  - rst_n low at cycle 20 → outputs 0 asynchronously; no done.
  - A fresh start afterwards completes normally in 41 cycles.
- FFT_SEQ_HOLD_EN: hold=1 for cycles 15–19 → done at cycle 46, same address/en sequence shifted, no en/wr_en during hold.

Source files
------------

// File: rtl/fft_butterfly_sequencer_if.sv
// Bus between the FFT butterfly sequencer and its consumers: the top-level
// control, sample RAM, twiddle ROM and butterfly adder.
//   start/busy/done          : transform handshake with top-level control
//   rd_valid/rd_addr_a/b     : sample RAM read request and address pair
//   tw_addr                  : twiddle ROM address for the issued butterfly
//   en/en_modify             : butterfly adder enable and last-stage modifier
//   stage                    : stage currently issuing (0 when idle)
//   wr_en/wr_addr_a/b        : sample RAM write-back strobe and address pair
//   hold (FFT_SEQ_HOLD_EN)   : freeze request, present only with that macro
interface fft_butterfly_sequencer_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned STG_W = 3
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_valid;
  logic [SIZE-1:0]     rd_addr_a;
  logic [SIZE-1:0]     rd_addr_b;
  logic [SIZE-2:0]     tw_addr;
  logic                en;
  logic                en_modify;
  logic [STG_W-1:0]    stage;
  logic                wr_en;
  logic [SIZE-1:0]     wr_addr_a;
  logic [SIZE-1:0]     wr_addr_b;
`ifdef FFT_SEQ_HOLD_EN
  logic                hold;
`endif

  // Sequencer side.
  modport master (
    input  start,
`ifdef FFT_SEQ_HOLD_EN
    input  hold,
`endif
    output busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
    output en, en_modify, stage, wr_en, wr_addr_a, wr_addr_b
  );

  // Control / memory / datapath side.
  modport slave (
    output start,
`ifdef FFT_SEQ_HOLD_EN
    output hold,
`endif
    input  busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
    input  en, en_modify, stage, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// Sequences a shared radix-2 butterfly datapath through all SIZE stages of an
// in-place DIT FFT of N = 2^SIZE points, one butterfly per clock, with BF_LAT
// bubble cycles between stages so the previous stage's writes land first.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fft_butterfly_sequencer_if.master (see interface header)
// Optional feature: define FFT_SEQ_HOLD_EN to add bus.hold, which freezes the
// FSM, counters and delay lines and masks rd_valid/en/wr_en/done while high.
module fft_butterfly_sequencer #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned BF_LAT = 2,
  parameter int unsigned STG_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  fft_butterfly_sequencer_if.master bus
);

  localparam int unsigned K_W   = SIZE - 1;
  localparam int unsigned TW_W  = SIZE - 1;
  localparam int unsigned HALF  = 1 << (SIZE - 1);
  localparam int unsigned CNT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUBBLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [STG_W-1:0]   stage_q;
  logic [K_W-1:0]     k_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_valid_q;
  logic [SIZE-1:0]    rd_addr_a_q;
  logic [SIZE-1:0]    rd_addr_b_q;
  logic [TW_W-1:0]    tw_addr_q;
  logic               en_q;
  logic               en_modify_q;
  logic [BF_LAT-1:0]  v_pipe;
  logic [SIZE-1:0]    a_pipe [BF_LAT];
  logic [SIZE-1:0]    b_pipe [BF_LAT];
  logic               hold_w;

`ifdef FFT_SEQ_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  // Upper address: insert a 0 bit at position s-1 of k.
  function automatic logic [SIZE-1:0] addr_a_of(input logic [STG_W-1:0] s,
                                                input logic [K_W-1:0]   kk);
    int unsigned sh;
    int unsigned pos;
    sh  = 32'(s) - 32'd1;
    pos = 32'(kk) & ((32'd1 << sh) - 32'd1);
    return SIZE'(((32'(kk) >> sh) << (sh + 32'd1)) | pos);
  endfunction

  // Lower address sits one span above the upper one.
  function automatic logic [SIZE-1:0] addr_b_of(input logic [STG_W-1:0] s,
                                                input logic [K_W-1:0]   kk);
    return addr_a_of(s, kk) | SIZE'(32'd1 << (32'(s) - 32'd1));
  endfunction

  // Twiddle index: position within the group scaled to the N/2 ROM.
  function automatic logic [TW_W-1:0] tw_of(input logic [STG_W-1:0] s,
                                            input logic [K_W-1:0]   kk);
    int unsigned sh;
    int unsigned pos;
    sh  = 32'(s) - 32'd1;
    pos = 32'(kk) & ((32'd1 << sh) - 32'd1);
    return TW_W'(pos << (SIZE - 1 - sh));
  endfunction

  // Sequencer FSM, issue registers and write-back delay lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      en_q        <= 1'b0;
      en_modify_q <= 1'b0;
      v_pipe      <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else if (!hold_w) begin
      en_q        <= rd_valid_q;
      en_modify_q <= rd_valid_q && (stage_q == STG_W'(SIZE));
      v_pipe[0]   <= rd_valid_q;
      a_pipe[0]   <= rd_addr_a_q;
      b_pipe[0]   <= rd_addr_b_q;
      for (int i = 1; i < BF_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_ISSUE;
            stage_q     <= STG_W'(1);
            k_q         <= '0;
            busy_q      <= 1'b1;
            rd_valid_q  <= 1'b1;
            rd_addr_a_q <= addr_a_of(STG_W'(1), '0);
            rd_addr_b_q <= addr_b_of(STG_W'(1), '0);
            tw_addr_q   <= tw_of(STG_W'(1), '0);
          end
        end
        S_ISSUE: begin
          if (k_q == K_W'(HALF - 1)) begin
            rd_valid_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= (stage_q == STG_W'(SIZE)) ? S_DRAIN : S_BUBBLE;
          end else begin
            k_q         <= k_q + K_W'(1);
            rd_addr_a_q <= addr_a_of(stage_q, k_q + K_W'(1));
            rd_addr_b_q <= addr_b_of(stage_q, k_q + K_W'(1));
            tw_addr_q   <= tw_of(stage_q, k_q + K_W'(1));
          end
        end
        S_BUBBLE: begin
          if (cnt_q == CNT_W'(BF_LAT - 1)) begin
            state_q     <= S_ISSUE;
            stage_q     <= stage_q + STG_W'(1);
            k_q         <= '0;
            rd_valid_q  <= 1'b1;
            rd_addr_a_q <= addr_a_of(stage_q + STG_W'(1), '0);
            rd_addr_b_q <= addr_b_of(stage_q + STG_W'(1), '0);
            tw_addr_q   <= tw_of(stage_q + STG_W'(1), '0);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // Last write-back appears during the final drain cycle.
          if (cnt_q == CNT_W'(BF_LAT - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          stage_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked while held; the registers behind them stay intact.
  assign bus.busy      = busy_q;
  assign bus.done      = done_q & ~hold_w;
  assign bus.rd_valid  = rd_valid_q & ~hold_w;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.en        = en_q & ~hold_w;
  assign bus.en_modify = en_modify_q & ~hold_w;
  assign bus.stage     = stage_q;
  assign bus.wr_en     = v_pipe[BF_LAT-1] & ~hold_w;
  assign bus.wr_addr_a = a_pipe[BF_LAT-1];
  assign bus.wr_addr_b = b_pipe[BF_LAT-1];

endmodule
